// File: rtl/serial_scale_mul.sv
// serial_scale_mul: serial shift-and-add multiplier for mixed-signedness operands,
// followed by a round-half-up right shift and saturation to OUT_W bits.
module serial_scale_mul #(
  parameter int N     = 8,
  parameter int OUT_W = 8,
  parameter int SW    = $clog2(2*N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic [SW-1:0]    shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   product,
  output logic             product_signed,
  output logic [OUT_W-1:0] scaled,
  output logic             sat
);

  localparam int EW = 2*N + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [EW-1:0] S_MAX = EW'(2**(OUT_W-1) - 1);
  localparam logic signed [EW-1:0] S_MIN = ~S_MAX;
  localparam logic        [EW-1:0] U_MAX = EW'(2**OUT_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, SCALE, OUT} state_t;

  state_t state, next_state;

  logic [N:0]      a_ext, b_ext, mag_a_c, mag_b_c;
  logic            sgn_a, sgn_b;
  logic [2*N:0]    mcand, acc, neg_acc;
  logic [N:0]      mplier;
  logic            neg, psg;
  logic [SW-1:0]   shift_r;
  logic [CW-1:0]   cnt;

  logic [2*N-1:0]        prod_c;
  logic [EW-1:0]         ext, rnd, sum, shd;
  logic signed [EW-1:0]  sum_s, ashr;
  logic [OUT_W-1:0]      scaled_c;
  logic                  sat_c;

  // Operand magnitudes; N+1 bits so that the most negative value keeps its magnitude.
  always_comb begin
    sgn_a   = a_signed & a[N-1];
    sgn_b   = b_signed & b[N-1];
    a_ext   = {sgn_a, a};
    b_ext   = {sgn_b, b};
    mag_a_c = sgn_a ? (~a_ext + 1'b1) : a_ext;
    mag_b_c = sgn_b ? (~b_ext + 1'b1) : b_ext;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = MUL;
      end
      MUL:   if (cnt == CW'(N-1)) next_state = SCALE;
      SCALE: next_state = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Sign application, widening, rounding, shift and saturation of the accumulated magnitude.
  always_comb begin
    neg_acc  = -acc;
    prod_c   = neg ? neg_acc[2*N-1:0] : acc[2*N-1:0];
    ext      = psg ? {{2{prod_c[2*N-1]}}, prod_c} : {2'b00, prod_c};
    rnd      = (shift_r != '0) ? (EW'(1) << (shift_r - 1'b1)) : '0;
    sum      = ext + rnd;
    sum_s    = sum;
    ashr     = sum_s >>> shift_r;
    shd      = psg ? ashr : (sum >> shift_r);
    scaled_c = shd[OUT_W-1:0];
    sat_c    = 1'b0;
    if (psg) begin
      if ($signed(shd) > S_MAX) begin
        scaled_c = S_MAX[OUT_W-1:0];
        sat_c    = 1'b1;
      end else if ($signed(shd) < S_MIN) begin
        scaled_c = S_MIN[OUT_W-1:0];
        sat_c    = 1'b1;
      end
    end else if (shd > U_MAX) begin
      scaled_c = '1;
      sat_c    = 1'b1;
    end
  end

  // Operand capture, serial accumulation and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      cnt            <= '0;
      neg            <= 1'b0;
      psg            <= 1'b0;
      shift_r        <= '0;
      product        <= '0;
      scaled         <= '0;
      sat            <= 1'b0;
      product_signed <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          mcand   <= {{N{1'b0}}, mag_a_c};
          mplier  <= mag_b_c;
          acc     <= '0;
          cnt     <= '0;
          neg     <= sgn_a ^ sgn_b;
          psg     <= a_signed | b_signed;
          shift_r <= shift;
        end
        // Multiplicand walks left and multiplier walks right, so bit i of |b|
        // always lands at mplier[0] alongside |a|<<i.
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        SCALE: begin
          product        <= prod_c;
          scaled         <= scaled_c;
          sat            <= sat_c;
          product_signed <= psg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_scale_mul.sv
// Directed self-checking bench for serial_scale_mul (N=8, OUT_W=8).
module tb_serial_scale_mul;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        a_signed, b_signed;
  logic [3:0]  shift;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        product_signed;
  logic [7:0]  scaled;
  logic        sat;

  int checks = 0;
  int errors = 0;

  localparam int LAT = 9; // edges after the acceptance edge until out_valid (cycle 10)

  serial_scale_mul #(.N(8), .OUT_W(8), .SW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .product_signed(product_signed), .scaled(scaled), .sat(sat)
  );

  always #5 clk = ~clk;

  // Issue one operand set (in_ready must be 1) and wait, bounded, for out_valid.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tas,
                       input logic tbs, input logic [3:0] tsh, output int lat);
    a = ta; b = tb; a_signed = tas; b_signed = tbs; shift = tsh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hA5; b = 8'h3C; a_signed = ~tas; b_signed = 1'b0; shift = 4'd7;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset;
    logic [25:0] got;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; shift = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    got = {product, scaled, sat, product_signed};
    checks++;
    if (got !== 26'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", got); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int lat;
    logic [25:0] got;
    do_op(8'h7F, 8'h7F, 1'b0, 1'b0, 4'd8, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL unsigned_latency: got %0d expected %0d", lat, LAT); end
    got = {product, scaled, sat, product_signed};
    checks++;
    if (got !== {16'h3F01, 8'h3F, 1'b0, 1'b0}) begin
      errors++; $display("FAIL unsigned_7f_7f: got %h expected %h", got, {16'h3F01, 8'h3F, 1'b0, 1'b0});
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL out_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL handshake_return: got %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_signed_min;
    int lat;
    logic [25:0] got;
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 4'd8, lat);
    got = {product, scaled, sat, product_signed};
    checks++;
    if (lat !== LAT || got !== {16'h4000, 8'h40, 1'b0, 1'b1}) begin
      errors++; $display("FAIL smin_sh8: got %h lat %0d expected %h lat %0d", got, lat, {16'h4000, 8'h40, 1'b0, 1'b1}, LAT);
    end
    @(posedge clk); #1;
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 4'd0, lat);
    got = {product, scaled, sat, product_signed};
    checks++;
    if (lat !== LAT || got !== {16'h4000, 8'h7F, 1'b1, 1'b1}) begin
      errors++; $display("FAIL smin_sh0_sat: got %h lat %0d expected %h", got, lat, {16'h4000, 8'h7F, 1'b1, 1'b1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mixed;
    int lat;
    logic [25:0] got;
    do_op(8'h80, 8'hFF, 1'b1, 1'b0, 4'd8, lat);
    got = {product, scaled, sat, product_signed};
    checks++;
    if (lat !== LAT || got !== {16'h8080, 8'h81, 1'b0, 1'b1}) begin
      errors++; $display("FAIL mixed_80s_ffu: got %h lat %0d expected %h", got, lat, {16'h8080, 8'h81, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    do_op(8'hFF, 8'h7F, 1'b1, 1'b1, 4'd4, lat);
    got = {product, scaled, sat, product_signed};
    checks++;
    if (lat !== LAT || got !== {16'hFF81, 8'hF8, 1'b0, 1'b1}) begin
      errors++; $display("FAIL signed_neg1_7f: got %h lat %0d expected %h", got, lat, {16'hFF81, 8'hF8, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_max;
    int lat;
    logic [25:0] got;
    logic [3:0]  sh [3] = '{4'd0, 4'd8, 4'd15};
    logic [7:0]  exp_s [3] = '{8'hFF, 8'hFE, 8'h02};
    logic        exp_sat [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(8'hFF, 8'hFF, 1'b0, 1'b0, sh[i], lat);
      got = {product, scaled, sat, product_signed};
      checks++;
      if (lat !== LAT || got !== {16'hFE01, exp_s[i], exp_sat[i], 1'b0}) begin
        errors++; $display("FAIL umax_sh%0d: got %h lat %0d expected %h", sh[i], got, lat, {16'hFE01, exp_s[i], exp_sat[i], 1'b0});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [25:0] got;
    logic [25:0] exp_v = {16'h03A8, 8'h3B, 1'b0, 1'b0};
    out_ready = 1'b0;
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 4'd4, lat);
    got = {product, scaled, sat, product_signed};
    checks++;
    if (lat !== LAT || got !== exp_v) begin
      errors++; $display("FAIL bp_result: got %h lat %0d expected %h", got, lat, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      a = 8'hFF; b = 8'hFF; a_signed = 1'b1; b_signed = 1'b1; shift = 4'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      got = {product, scaled, sat, product_signed};
      checks++;
      if (got !== exp_v || {out_valid, in_ready} !== 2'b10) begin
        errors++; $display("FAIL bp_hold_%0d: got %h vr %b expected %h vr 10", i, got, {out_valid, in_ready}, exp_v);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release: got %b expected 01", {out_valid, in_ready});
    end
    repeat (3) @(posedge clk);
    #1;
    got = {product, scaled, sat, product_signed};
    checks++;
    if (got !== exp_v || {out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_idle_keep: got %h vr %b expected %h vr 01", got, {out_valid, in_ready}, exp_v);
    end
  endtask

  task automatic test_reset_abort;
    logic [25:0] got;
    int seen;
    a = 8'h7F; b = 8'h7F; a_signed = 1'b0; b_signed = 1'b0; shift = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    got = {product, scaled, sat, product_signed};
    checks++;
    if (got !== 26'h0 || {out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL abort_reset: got %h vr %b expected 0 vr 01", got, {out_valid, in_ready});
    end
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [25:0] got;
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 4'd8, lat);
    got = {product, scaled, sat, product_signed};
    checks++;
    if (lat !== LAT || got !== {16'h4000, 8'h40, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b2b_first: got %h lat %0d expected %h", got, lat, {16'h4000, 8'h40, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
    do_op(8'hFF, 8'h7F, 1'b1, 1'b1, 4'd4, lat);
    got = {product, scaled, sat, product_signed};
    checks++;
    if (lat !== LAT || got !== {16'hFF81, 8'hF8, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d expected %h", got, lat, {16'hFF81, 8'hF8, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    do_op(8'hFD, 8'h05, 1'b1, 1'b0, 4'd0, lat);
    got = {product, scaled, sat, product_signed};
    checks++;
    if (lat !== LAT || got !== {16'hFFF1, 8'hF1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b2b_third: got %h lat %0d expected %h", got, lat, {16'hFFF1, 8'hF1, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_min();
    test_mixed();
    test_unsigned_max();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
